seq_mult_ctrl: RTL
==================

Name: seq_mult_ctrl

Overview:
Upstream sequencer for the 8x8 shift-add sequential multiplier (SeqMultiplier) in the arithmetic lab datapath.
- Accepts operand pairs over a valid/ready handshake and holds them stable.
- Drives the multiplier's active-low-load `enable` through load and run phases, captures the 16-bit product, and presents it on a valid/ready result interface.
- Lets the free-running multiplier be used as a transaction-based unit with a defined latency.

Parameters:
- `WIDTH`, 8: operand width; the product is 2*WIDTH. The multiplier is fixed at 8, so only 8 is supported.
- `RUN_CYCLES`, 8: cycles `mul_enable` is held high per operation. Must be >= `WIDTH`; elaboration-time assert.
- `CNT_W`, 8: width of the `op_count` statistics counter.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: block can accept an operand pair.
- `in_a`, in, WIDTH: multiplicand.
- `in_b`, in, WIDTH: multiplier.
- `mul_enable`, out, 1: to multiplier `enable`; low = load/clear, high = iterate.
- `mul_a`, out, WIDTH: to multiplier A, registered.
- `mul_b`, out, WIDTH: to multiplier B, registered.
- `mul_c`, in, 2*WIDTH: product from multiplier C.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_prod`, out, 2*WIDTH: captured product.
- `busy`, out, 1: high in every state except IDLE.
- `op_count`, out, CNT_W: completed (handed-off) results; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, `in_ready` = 1, `mul_enable` = 0.
  - `mul_a`, `mul_b`, `out_prod`, `op_count`, run counter all = 0.
  - `out_valid` = 0, `busy` = 0.
- FSM states: IDLE, LOAD, RUN, CAP, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - `in_ready` = 1, `mul_enable` = 0.
  - On `in_valid` & `in_ready`: register `in_a` into `mul_a` and `in_b` into `mul_b`, then go to LOAD.
- LOAD (1 cycle):
  - `mul_enable` = 0, so the multiplier latches B and clears its product at this edge.
  - Clear the run counter and go to RUN.
- RUN (exactly `RUN_CYCLES` cycles):
  - `mul_enable` = 1; `mul_a` and `mul_b` are held stable.
  - Run counter increments each cycle.
  - When the counter == `RUN_CYCLES`-1, go to CAP.
- CAP (1 cycle):
  - `mul_enable` = 0.
  - Register `out_prod` <= `mul_c`. This edge samples the multiplier's final product; its reload in the same edge does not disturb the sampled value.
  - Set `out_valid` = 1 and go to DONE.
- DONE:
  - `out_valid` = 1; `out_prod` is held stable while `out_ready` is low (no drop, no change).
  - On `out_ready`: `out_valid` -> 0, `op_count` += 1, go to IDLE.
- Latency: with the accept edge = cycle 0, LOAD = cycle 1, RUN = cycles 2..9, CAP = cycle 10, and `out_valid` is first high in cycle 11 (default parameters).
- Throughput: one operation per 12 cycles with `out_ready` tied high (LOAD + 8 RUN + CAP + DONE + IDLE). `in_ready` is low except in IDLE, so there is no skid buffer and no overlap.
- Arithmetic: unsigned throughout. The product is taken verbatim from `mul_c`, with no truncation or extension.
- Inputs while busy: `in_valid` outside IDLE is ignored, and `in_a`/`in_b` changes have no effect.
- Reset mid-operation: immediately returns to reset values. The in-flight operation is discarded, and no result or count increment occurs.
- `op_count` wraps 2^CNT_W-1 -> 0 silently.

Decomposition:
- Package `seq_mult_pkg`:
  - State enum `mult_state_t` (IDLE, LOAD, RUN, CAP, DONE).
  - Localparams `MULT_W` = 8, `PROD_W` = 16.
  - Run-counter width `$clog2(RUN_CYCLES+1)`.
- No sub-module. The FSM, run counter and output registers are inline. The multiplier is instantiated beside this block by the parent, not inside it.

Test Plan:
- Basic multiply: `in_a` = 13, `in_b` = 11, `out_ready` = 1. Required: `out_prod` = 0x008F with `out_valid` first high exactly 11 cycles after the accept edge; `op_count` = 1; `mul_enable` high for exactly 8 consecutive cycles.
- Extremes, back-to-back: 255*255 then 0*200 then 1*255. Required: 0xFE01, 0x0000, 0x00FF in order; `in_ready` reasserts one cycle after each handoff.
- Back-pressure: 200*3 with `out_ready` held low 20 cycles. Required: `out_valid` held, `out_prod` = 0x0258 stable throughout; `in_valid` pulses with other operands are ignored (`in_ready` = 0); a single count increment on release.
- Reset mid-RUN: assert `rst_n` = 0 at RUN cycle 4 of 37*5. Required: all outputs return to reset values asynchronously; no `out_valid`; `op_count` unchanged at 0; the next operation 6*7 returns 0x002A.
- Operand stability: change `in_a`/`in_b` every cycle during RUN for 100*100. Required: `mul_a`/`mul_b` constant at 100; result 0x2710.
- Counter wrap (CNT_W = 2): perform 5 operations. Required: `op_count` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and constants for the sequential-multiplier sequencer.
// Holds the FSM state encoding, the fixed multiplier widths and the
// sizing helper for the run counter.
package seq_mult_pkg;

  localparam int MULT_W = 8;
  localparam int PROD_W = 2 * MULT_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CAP  = 3'd3,
    DONE = 3'd4
  } mult_state_t;

  // Run counter must be able to hold RUN_CYCLES itself, not just RUN_CYCLES-1.
  function automatic int run_cnt_w(input int run_cycles);
    return $clog2(run_cycles + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand and result handshake bundle for the multiplier sequencer.
// master = the operand producer / result consumer, slave = the sequencer.
// Both directions use plain valid/ready; a beat moves when both are high.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Sequencer turning the free-running 8x8 shift-add multiplier into a transaction unit.
// Latency: accept edge to out_valid is 11 cycles (LOAD + RUN_CYCLES RUN + CAP), one op per 12 cycles.
// Backpressure: in_ready only in IDLE (no overlap); result is held in DONE until out_ready.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH      = MULT_W,
  parameter int RUN_CYCLES = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_mult_ctrl_if.slave     bus,
  output logic               mul_enable,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_c,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam int RUN_CNT_W = run_cnt_w(RUN_CYCLES);
  localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(RUN_CYCLES - 1);

  // The attached multiplier is hard-wired to 8 bits and needs at least WIDTH iterations.
  if (WIDTH != MULT_W) begin : g_width_chk
    $error("seq_mult_ctrl: WIDTH must be %0d", MULT_W);
  end
  if (RUN_CYCLES < WIDTH) begin : g_run_chk
    $error("seq_mult_ctrl: RUN_CYCLES must be >= WIDTH");
  end

  mult_state_t            state_q,    state_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q,  run_cnt_d;
  logic [WIDTH-1:0]       mul_a_q,    mul_a_d;
  logic [WIDTH-1:0]       mul_b_q,    mul_b_d;
  logic [2*WIDTH-1:0]     out_prod_q, out_prod_d;
  logic [CNT_W-1:0]       op_count_q, op_count_d;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      run_cnt_q  <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      out_prod_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      out_prod_q <= out_prod_d;
      op_count_q <= op_count_d;
    end
  end

  // Next-state and register updates; operands only move in IDLE so they stay frozen while busy.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    out_prod_d = out_prod_q;
    op_count_d = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        if (run_cnt_q == RUN_LAST) begin
          state_d = CAP;
        end
      end
      CAP: begin
        // The multiplier reloads on this same edge, but the value sampled here is its final product.
        out_prod_d = mul_c;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control outputs are decoded from state only, so no input reaches an output combinationally.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_prod  = out_prod_q;
  assign mul_enable    = (state_q == RUN);
  assign busy          = (state_q != IDLE);
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign op_count      = op_count_q;

endmodule
